// File: rtl/btn_switch_conditioner.sv
// Button/switch input conditioner: synchronizes the raw button and switches, debounces the
// button, and emits a one-cycle start pulse with a switch snapshot on each accepted press.
module btn_switch_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter int SW_W            = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            button_raw,
  input  logic [SW_W-1:0] switch_raw,
  output logic            btn_pulse,
  output logic            btn_level,
  output logic [SW_W-1:0] switch_snap,
  output logic [1:0]      state_dbg
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic            b_s1;
  logic            b_s2;
  logic [SW_W-1:0] sw_s1;
  logic [SW_W-1:0] sw_s2;
  state_t          state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_s1  <= 1'b0;
      b_s2  <= 1'b0;
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      b_s1  <= button_raw;
      b_s2  <= b_s1;
      sw_s1 <= switch_raw;
      sw_s2 <= sw_s1;
    end
  end

  // A b_s2 mismatch is tested before the terminal count, so bounce always wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      btn_pulse   <= 1'b0;
      btn_level   <= 1'b0;
      switch_snap <= '0;
    end else begin
      btn_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (b_s2) begin
            state <= PRESS_CHK;
            cnt   <= '0;
          end
        end
        PRESS_CHK: begin
          if (!b_s2) begin
            state <= IDLE;
          end else if (cnt == CNT_LAST) begin
            state       <= HELD;
            btn_pulse   <= 1'b1;
            btn_level   <= 1'b1;
            switch_snap <= sw_s2;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: begin
          if (!b_s2) begin
            state <= REL_CHK;
            cnt   <= '0;
          end
        end
        REL_CHK: begin
          if (b_s2) begin
            state <= HELD;
          end else if (cnt == CNT_LAST) begin
            state     <= IDLE;
            btn_level <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign state_dbg = state;

endmodule
